multi_read_ff_ram: RTL and testbench
====================================

# multi_read_ff_ram

Flip-flop RAM for cache metadata and small tag/state arrays. It provides multiple independent read ports, byte-granular writes, a per-entry valid bit, and a single-cycle bulk clear. Read latency is selectable as combinational or registered, and same-cycle write-to-read forwarding is optional. It sits under the cache tag/meta logic wherever contents must be fully resettable and invalidatable without a sweep FSM.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH
- NUM_RPORTS, 2, number of independent read ports, at least 1
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read
- BYPASS, 1, 1 = reads forward same-cycle write data, 0 = reads see pre-write contents
- Derived: NUM_BYTES = DATA_WIDTH/8

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low; clock clk
- clear  in  1  invalidate and zero all entries at the next edge
- write_en  in  1  write request
- waddr  in  ADDR_WIDTH  write address
- wstrb  in  NUM_BYTES  byte enables; bit b covers wdata[8b+7:8b]
- wdata  in  DATA_WIDTH  write data
- ren  in  NUM_RPORTS  per-port read enable; used only when READ_LATENCY=1
- raddr  in  NUM_RPORTS x ADDR_WIDTH  per-port read address
- rdata  out  NUM_RPORTS x DATA_WIDTH  per-port read data
- rvalid  out  NUM_RPORTS  valid bit of the entry read

## Operation
- Storage per entry: DATA_WIDTH data bits plus 1 valid bit.
- Reset (resetn=0 at a posedge):
  - All data and valid bits go to 0.
  - Registered read outputs go to 0.
  - clear, write_en and ren are ignored during that edge.
- Write (write_en=1):
  - Bytes with wstrb[b]=1 take the new data; other bytes keep their old value.
  - The entry's valid bit is set to 1, even when wstrb=0.
- Clear (clear=1):
  - All entries' data and valid bits go to 0.
  - If write_en is also 1, the write is applied on top of the cleared state. waddr ends up valid=1, with wstrb bytes from wdata and the remaining bytes 0. All other entries end up 0 and invalid.
- Read, per port i:
  - The source word is mem[raddr[i]] with its valid bit.
  - With BYPASS=1 and write_en=1 and waddr==raddr[i], the source is the post-edge value of that entry: merged bytes, valid=1, and zero base bytes if clear=1.
  - With BYPASS=1 and clear=1 and no address match, the source is still the pre-edge contents. Forwarding applies to writes only.
  - With BYPASS=0, the source is always pre-edge contents.
  - Ports are fully independent. Any number of ports may hold the same address.
- READ_LATENCY=0:
  - rdata and rvalid follow the source combinationally.
  - No output state exists and ren is unused.
  - Before the first reset, reads return X.
- READ_LATENCY=1:
  - Each port has an output register loaded with the source at posedge when ren[i]=1. It holds its value when ren[i]=0.
  - The register is zeroed at reset, and its reset value is rdata=0, rvalid=0.
  - clear does not alter the output registers except through the loaded source.

## Timing
- Write and clear take effect at the posedge where they are sampled. The array shows them from the following cycle.
- Read latency:
  - READ_LATENCY=0: 0 cycles.
  - READ_LATENCY=1: 1 cycle from ren/raddr to rdata/rvalid.
- Forwarding, when BYPASS=1:
  - Latency 0: data appears in the same cycle as write_en.
  - Latency 1: the register captures forwarded data, so it is visible the cycle after.
- Read-after-write to the same address in the next cycle always sees new data, regardless of BYPASS.
- Reset asserted mid-operation discards any same-edge write or clear. Outputs are 0 in the cycle after reset.
- No backpressure: a write completes in one cycle and every port accepts a read every cycle.

## Structure
- A shared cache RAM package holds the write-merge function, merge(old, wdata, wstrb) -> word. Tag arrays use it too.
- Elaboration-time checks: DATA_WIDTH%8==0, NUM_RPORTS>=1, READ_LATENCY in {0,1}.
- The array, valid vector and write/clear logic form one always_ff block.
- Read logic uses a generate loop over ports instantiating sub-module ff_ram_read_port, which does the bypass mux plus the optional output register. It is parametrised by DATA_WIDTH, ADDR_WIDTH, READ_LATENCY and BYPASS.

## Test plan
- Reset then read: read all addresses on all ports -> rdata=0, rvalid=0 everywhere. With latency 1, outputs are 0 in the first post-reset cycle.
- Byte-enable write: write 0xAABBCCDD with strb=1111 to addr 3, then 0x11223344 with strb=0101 to addr 3 -> read gives 0xAA22CC44, rvalid=1.
- Bypass:
  - With BYPASS=1, latency 0: write 0xDEADBEEF to addr 5 while port 1 reads addr 5 -> same cycle rdata=0xDEADBEEF, rvalid=1.
  - With BYPASS=0 -> old value 0, rvalid=0 in that cycle, then 0xDEADBEEF next cycle.
- Clear with write: fill addrs 0–15, then in one cycle clear=1 with a write to addr 7 of 0x000000FF, strb=0001 -> addr 7 reads 0x000000FF, valid=1. All other addresses read 0, valid=0.
- Registered hold: with latency 1, read addr 2 with ren=1, then ren=0 while addr 2 is rewritten -> rdata holds the old value until ren returns to 1.
- Reset mid-write: resetn=0 together with write_en=1 to addr 9 -> addr 9 reads 0, valid=0 after reset.

Source files
------------

// File: rtl/multi_read_ff_ram_pkg.sv
// Shared definitions for the flip-flop cache RAMs: byte-granular write merge
// and read-latency encodings used by the read ports.
package multi_read_ff_ram_pkg;

    localparam int MERGE_MAX_WIDTH = 512;
    localparam int MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

    typedef logic [MERGE_MAX_WIDTH-1:0] merge_word_t;
    typedef logic [MERGE_MAX_BYTES-1:0] merge_strb_t;

    localparam int READ_COMB = 0;
    localparam int READ_REG  = 1;

    // Callers zero-extend narrower words and truncate the result back.
    function automatic merge_word_t merge(input merge_word_t old_word,
                                          input merge_word_t wdata,
                                          input merge_strb_t wstrb);
        merge_word_t result;
        result = old_word;
        for (int b = 0; b < MERGE_MAX_BYTES; b++) begin
            if (wstrb[b]) begin
                result[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/multi_read_ff_ram_read_port.sv
// One read port: optional same-cycle write forwarding followed by an
// optional output register.
module ff_ram_read_port
    import multi_read_ff_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS       = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ren_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_valid_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] write_word_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    logic                  fwd;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;

    // write_word_i already holds the post-edge entry value, clear included.
    always_comb begin
        fwd       = (BYPASS != 0) && write_en_i && (waddr_i == raddr_i);
        src_data  = fwd ? write_word_i : mem_data_i;
        src_valid = fwd || mem_valid_i;
    end

    generate
        if (READ_LATENCY == READ_REG) begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = ren_i ? src_data  : rdata_q;
                rvalid_d = ren_i ? src_valid : rvalid_q;
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end else begin : g_comb
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, resetn, ren_i};
            assign rdata_o  = src_data;
            assign rvalid_o = src_valid;
        end
    endgenerate

endmodule

// File: rtl/multi_read_ff_ram.sv
// Flip-flop RAM with per-entry valid, byte-strobed writes, single-cycle bulk
// clear and NUM_RPORTS independent read ports.
module multi_read_ff_ram
    import multi_read_ff_ram_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 4,
    parameter  int NUM_RPORTS   = 2,
    parameter  int READ_LATENCY = 0,
    parameter  int BYPASS       = 1,
    localparam int NUM_BYTES    = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  clear,
    input  logic                                  write_en,
    input  logic [ADDR_WIDTH-1:0]                 waddr,
    input  logic [NUM_BYTES-1:0]                  wstrb,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic [NUM_RPORTS-1:0]                 ren,
    input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata,
    output logic [NUM_RPORTS-1:0]                 rvalid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MERGE_MAX_WIDTH) begin : g_bad_width
            $error("multi_read_ff_ram: DATA_WIDTH must be a multiple of 8 and <= %0d", MERGE_MAX_WIDTH);
        end
        if (NUM_RPORTS < 1) begin : g_bad_ports
            $error("multi_read_ff_ram: NUM_RPORTS must be at least 1");
        end
        if (READ_LATENCY != READ_COMB && READ_LATENCY != READ_REG) begin : g_bad_latency
            $error("multi_read_ff_ram: READ_LATENCY must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] write_base;
    logic [DATA_WIDTH-1:0] write_word;

    // A write in the same cycle as clear merges onto a zeroed entry.
    always_comb begin
        write_base = clear ? '0 : mem_q[waddr];
        write_word = DATA_WIDTH'(merge(merge_word_t'(write_base),
                                       merge_word_t'(wdata),
                                       merge_strb_t'(wstrb)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                valid_q <= '0;
            end
            if (write_en) begin
                mem_q[waddr]   <= write_word;
                valid_q[waddr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
            ff_ram_read_port #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ADDR_WIDTH  (ADDR_WIDTH),
                .READ_LATENCY(READ_LATENCY),
                .BYPASS      (BYPASS)
            ) u_port (
                .clk         (clk),
                .resetn      (resetn),
                .ren_i       (ren[gi]),
                .raddr_i     (raddr[gi]),
                .mem_data_i  (mem_q[raddr[gi]]),
                .mem_valid_i (valid_q[raddr[gi]]),
                .write_en_i  (write_en),
                .waddr_i     (waddr),
                .write_word_i(write_word),
                .rdata_o     (rdata[gi]),
                .rvalid_o    (rvalid[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_read_ff_ram.sv
// Checks three configurations (comb+bypass, comb no-bypass, registered+bypass)
// sharing one stimulus stream against an array-level reference model.
module tb_multi_read_ff_ram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NP    = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic                  clk;
    logic                  resetn;
    logic                  clear;
    logic                  write_en;
    logic [AW-1:0]         waddr;
    logic [NB-1:0]         wstrb;
    logic [DW-1:0]         wdata;
    logic [NP-1:0]         ren;
    logic [NP-1:0][AW-1:0] raddr;

    logic [NP-1:0][DW-1:0] rdata_a, rdata_b, rdata_c;
    logic [NP-1:0]         rvalid_a, rvalid_b, rvalid_c;

    int total = 0;
    int bad   = 0;

    multi_read_ff_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NP),
                        .READ_LATENCY(0), .BYPASS(1)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear), .write_en(write_en),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a));

    multi_read_ff_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NP),
                        .READ_LATENCY(0), .BYPASS(0)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear), .write_en(write_en),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b));

    multi_read_ff_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NP),
                        .READ_LATENCY(1), .BYPASS(1)) dut_c (
        .clk(clk), .resetn(resetn), .clear(clear), .write_en(write_en),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: array contents plus the registered-read outputs.
    logic [DW-1:0] m_data  [DEPTH];
    logic          m_valid [DEPTH];
    logic [DW-1:0] r_data  [NP];
    logic          r_valid [NP];

    function automatic logic [DW-1:0] model_write_word();
        logic [DW-1:0] w;
        w = clear ? '0 : m_data[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        return w;
    endfunction

    function automatic logic [DW:0] model_src(input int ra, input bit byp);
        if (byp && write_en && int'(waddr) == ra) begin
            return {1'b1, model_write_word()};
        end
        return {m_valid[ra], m_data[ra]};
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i]  <= '0;
                m_valid[i] <= 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                r_data[p]  <= '0;
                r_valid[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (ren[p]) {r_valid[p], r_data[p]} <= model_src(int'(raddr[p]), 1'b1);
            end
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_data[i]  <= '0;
                    m_valid[i] <= 1'b0;
                end
            end
            if (write_en) begin
                m_data[waddr]  <= model_write_word();
                m_valid[waddr] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int port, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s port%0d t=%0t got=%h want=%h", name, port, $time, got, want);
        end
    endtask

    task automatic compare_all();
        logic [DW:0] e;
        for (int p = 0; p < NP; p++) begin
            e = model_src(int'(raddr[p]), 1'b1);
            chk("A.rdata", p, rdata_a[p], e[DW-1:0]);
            chk("A.rvalid", p, DW'(rvalid_a[p]), DW'(e[DW]));
            e = model_src(int'(raddr[p]), 1'b0);
            chk("B.rdata", p, rdata_b[p], e[DW-1:0]);
            chk("B.rvalid", p, DW'(rvalid_b[p]), DW'(e[DW]));
            chk("C.rdata", p, rdata_c[p], r_data[p]);
            chk("C.rvalid", p, DW'(rvalid_c[p]), DW'(r_valid[p]));
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        compare_all();
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        write_en = 1'b1;
        waddr    = AW'(a);
        wdata    = d;
        wstrb    = s;
    endtask

    initial begin
        resetn = 1'b0; clear = 1'b0; write_en = 1'b0;
        waddr = '0; wstrb = '0; wdata = '0; ren = '0; raddr = '0;
        to_next();
        at_neg(); to_next();
        resetn = 1'b1;

        // Every address reads zero and invalid after reset
        ren = '1;
        for (int a = 0; a < DEPTH; a++) begin
            raddr[0] = AW'(a);
            raddr[1] = AW'(DEPTH - 1 - a);
            at_neg();
            if (a == 0) begin
                chk("lit.C.rdata.postreset", 0, rdata_c[0], 32'h0);
                chk("lit.C.rvalid.postreset", 0, DW'(rvalid_c[0]), 32'h0);
            end
            chk("lit.A.rdata.reset", 0, rdata_a[0], 32'h0);
            chk("lit.A.rvalid.reset", 1, DW'(rvalid_a[1]), 32'h0);
            to_next();
        end
        ren = '0;

        // Byte-strobed writes
        raddr[0] = 4'd3;
        do_write(3, 32'hAABBCCDD, 4'b1111);
        at_neg();
        chk("lit.A.bypass.full", 0, rdata_a[0], 32'hAABBCCDD);
        chk("lit.B.nobypass.old", 0, rdata_b[0], 32'h0);
        to_next();
        do_write(3, 32'h11223344, 4'b0101);
        at_neg();
        chk("lit.A.bypass.merge", 0, rdata_a[0], 32'hAA22CC44);
        to_next();
        write_en = 1'b0;
        at_neg();
        chk("lit.B.merge", 0, rdata_b[0], 32'hAA22CC44);
        chk("lit.B.merge.valid", 0, DW'(rvalid_b[0]), 32'h1);
        to_next();

        // Forwarding vs pre-edge contents
        raddr[1] = 4'd5;
        ren = 2'b10;
        do_write(5, 32'hDEADBEEF, 4'b1111);
        at_neg();
        chk("lit.A.fwd", 1, rdata_a[1], 32'hDEADBEEF);
        chk("lit.A.fwd.valid", 1, DW'(rvalid_a[1]), 32'h1);
        chk("lit.B.nofwd", 1, rdata_b[1], 32'h0);
        chk("lit.B.nofwd.valid", 1, DW'(rvalid_b[1]), 32'h0);
        to_next();
        write_en = 1'b0;
        ren = '0;
        at_neg();
        chk("lit.B.next", 1, rdata_b[1], 32'hDEADBEEF);
        chk("lit.C.fwdreg", 1, rdata_c[1], 32'hDEADBEEF);
        chk("lit.C.fwdreg.valid", 1, DW'(rvalid_c[1]), 32'h1);
        to_next();

        // Fill, then clear combined with a write to address 7
        for (int i = 0; i < DEPTH; i++) begin
            do_write(i, 32'h1000_0000 + i, 4'b1111);
            at_neg(); to_next();
        end
        clear = 1'b1;
        do_write(7, 32'h000000FF, 4'b0001);
        raddr[0] = 4'd7;
        raddr[1] = 4'd6;
        at_neg();
        chk("lit.A.clearfwd", 0, rdata_a[0], 32'h000000FF);
        chk("lit.A.clear.preedge", 1, rdata_a[1], 32'h10000006);
        to_next();
        clear = 1'b0;
        write_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            raddr[0] = AW'(i);
            at_neg();
            chk("lit.B.afterclear", 0, rdata_b[0], (i == 7) ? 32'h000000FF : 32'h0);
            chk("lit.B.afterclear.valid", 0, DW'(rvalid_b[0]), (i == 7) ? 32'h1 : 32'h0);
            to_next();
        end

        // Registered output holds while ren is low
        do_write(2, 32'h12345678, 4'b1111);
        at_neg(); to_next();
        write_en = 1'b0;
        ren = 2'b01;
        raddr[0] = 4'd2;
        at_neg(); to_next();
        ren = 2'b00;
        do_write(2, 32'h00000009, 4'b1111);
        at_neg();
        chk("lit.C.hold1", 0, rdata_c[0], 32'h12345678);
        to_next();
        write_en = 1'b0;
        at_neg();
        chk("lit.C.hold2", 0, rdata_c[0], 32'h12345678);
        to_next();
        ren = 2'b01;
        at_neg();
        chk("lit.C.hold3", 0, rdata_c[0], 32'h12345678);
        to_next();
        ren = 2'b00;
        at_neg();
        chk("lit.C.reload", 0, rdata_c[0], 32'h00000009);
        to_next();

        // Reset discards a same-edge write
        resetn = 1'b0;
        ren = 2'b01;
        raddr[0] = 4'd9;
        do_write(9, 32'h00000055, 4'b1111);
        at_neg(); to_next();
        resetn = 1'b1;
        write_en = 1'b0;
        at_neg();
        chk("lit.A.rstwrite", 0, rdata_a[0], 32'h0);
        chk("lit.A.rstwrite.valid", 0, DW'(rvalid_a[0]), 32'h0);
        chk("lit.C.rst", 0, rdata_c[0], 32'h0);
        to_next();
        ren = 2'b00;
        at_neg();
        chk("lit.C.rstread", 0, rdata_c[0], 32'h0);
        chk("lit.C.rstread.valid", 0, DW'(rvalid_c[0]), 32'h0);
        to_next();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            resetn   = ($urandom_range(0, 99) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            write_en = $urandom_range(0, 1) == 1;
            waddr    = AW'($urandom);
            wstrb    = NB'($urandom);
            wdata    = $urandom;
            ren      = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                raddr[p] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom);
            end
            at_neg(); to_next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
